// File: rtl/ccd_pixel_stream.sv
// ----------------------------------------------------------------------------
// ccd_pixel_stream
//   Turns 16-bit CCD pixel words (plus an optional frame sync word) into a
//   byte stream, MSB first. Bytes are held in a byte FIFO and offered on a
//   first-word-fall-through valid/ready port for the FT245 writer. The ADC
//   side cannot be stalled, so a word that cannot be stored is dropped and
//   recorded in the sticky overflow flag.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   pix_data     pixel word from the AD9826 capture logic
//   pix_valid    one-cycle strobe qualifying pix_data
//   frame_start  one-cycle strobe: queue SYNC_WORD and clear pix_count
//   flush        synchronous clear of FIFO, writer and flags
//   tx_data      FIFO head byte (0 while empty)
//   tx_valid     FIFO non-empty
//   tx_ready     consumer takes tx_data this cycle
//   fill_level   bytes currently stored
//   overflow     sticky: at least one word was dropped
//   pix_count    pixels accepted since last frame_start/flush/rst
// ----------------------------------------------------------------------------
module ccd_pixel_stream #(
    parameter int          ADDR_W    = 9,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pix_data,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic              flush,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow,
    output logic [15:0]       pix_count
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LO   = 1'b1
    } wr_state_t;

    wr_state_t         state_r;
    wr_state_t         state_nxt_s;
    logic [7:0]        lo_byte_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_nxt_s;
    logic [ADDR_W:0]   fill_r;
    logic [ADDR_W:0]   fill_nxt_s;
    logic [ADDR_W:0]   fill_after_pop_s;
    logic [7:0]        mem_r [0:DEPTH-1];
    logic [7:0]        tx_data_r;
    logic [7:0]        tx_data_nxt_s;
    logic              tx_valid_r;
    logic              overflow_r;
    logic [15:0]       pix_count_r;
    logic [15:0]       pix_count_nxt_s;

    logic              clear_s;
    logic              pop_s;
    logic              space_ok_s;
    logic              cand_s;
    logic [15:0]       cand_word_s;
    logic              accept_s;
    logic              wr_en_s;
    logic [7:0]        wr_byte_s;
    logic              drop_s;

    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;
    assign fill_level = fill_r;
    assign overflow   = overflow_r;
    assign pix_count  = pix_count_r;

    // Writer decisions, FIFO bookkeeping and next head byte
    always_comb begin
        clear_s     = rst | flush;
        pop_s       = tx_valid_r & tx_ready;
        // A same-cycle pop is deliberately not credited: space is judged on
        // the registered fill so a word is only started with room for both bytes.
        space_ok_s  = ((DEPTH_L - fill_r) >= (ADDR_W + 1)'(2));
        cand_s      = frame_start | pix_valid;
        cand_word_s = frame_start ? SYNC_WORD : pix_data;
        accept_s    = 1'b0;
        wr_en_s     = 1'b0;
        wr_byte_s   = 8'h00;
        drop_s      = 1'b0;
        state_nxt_s = state_r;

        case (state_r)
            ST_IDLE: begin
                if (cand_s && space_ok_s) begin
                    accept_s    = 1'b1;
                    wr_en_s     = 1'b1;
                    wr_byte_s   = cand_word_s[15:8];
                    state_nxt_s = ST_LO;
                end else begin
                    accept_s    = 1'b0;
                end
                // A pixel colliding with frame_start loses, as does any
                // candidate refused for space.
                drop_s = (frame_start & pix_valid) | (cand_s & ~space_ok_s);
            end
            ST_LO: begin
                wr_en_s     = 1'b1;
                wr_byte_s   = lo_byte_r;
                state_nxt_s = ST_IDLE;
                drop_s      = cand_s;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (frame_start) begin
            pix_count_nxt_s = 16'h0000;
        end else if (accept_s) begin
            pix_count_nxt_s = pix_count_r + 16'h0001;
        end else begin
            pix_count_nxt_s = pix_count_r;
        end

        fill_after_pop_s = fill_r - (ADDR_W + 1)'(pop_s);
        fill_nxt_s       = fill_after_pop_s + (ADDR_W + 1)'(wr_en_s);

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // The head byte is registered; when the FIFO is (or becomes) empty
        // apart from this edge's write, that write is the new head.
        if (fill_nxt_s == (ADDR_W + 1)'(0)) begin
            tx_data_nxt_s = 8'h00;
        end else if (fill_after_pop_s == (ADDR_W + 1)'(0)) begin
            tx_data_nxt_s = wr_byte_s;
        end else begin
            tx_data_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Byte storage; contents need no reset since fill/pointers gate them
    always_ff @(posedge clk) begin
        if (!clear_s && wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_byte_s;
        end
    end

    // Writer FSM, pointers, flags and registered read-side outputs
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r     <= ST_IDLE;
            lo_byte_r   <= 8'h00;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            fill_r      <= '0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            pix_count_r <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            if (accept_s) begin
                lo_byte_r <= cand_word_s[7:0];
            end
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            fill_r      <= fill_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            tx_valid_r  <= (fill_nxt_s != (ADDR_W + 1)'(0));
            overflow_r  <= overflow_r | drop_s;
            pix_count_r <= pix_count_nxt_s;
        end
    end

endmodule

// File: tb/tb_ccd_pixel_stream.sv
module tb_ccd_pixel_stream;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic [15:0]   pix_data;
    logic          pix_valid;
    logic          frame_start;
    logic          flush;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW:0]   fill_level;
    logic          overflow;
    logic [15:0]   pix_count;

    int            n_vec;
    int            n_err;
    logic [7:0]    got[$];
    int            m_fill;
    bit            m_lo;

    ccd_pixel_stream #(.ADDR_W(AW), .SYNC_WORD(16'hA55A)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .flush       (flush),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .pix_count   (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Records the byte popped at the coming edge, advances the fill model,
    // then moves to 1 time unit after the edge.
    task automatic step();
        int wr;
        int pp;
        if (!rst && !flush && tx_valid && tx_ready) got.push_back(tx_data);
        if (rst || flush) begin
            m_fill = 0;
            m_lo   = 1'b0;
        end else begin
            wr = 0;
            if (m_lo) begin
                wr   = 1;
                m_lo = 1'b0;
            end else if ((frame_start || pix_valid) && (DEPTH - m_fill) >= 2) begin
                wr   = 1;
                m_lo = 1'b1;
            end
            pp     = (m_fill != 0 && tx_ready) ? 1 : 0;
            m_fill = m_fill + wr - pp;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        got.delete();
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_fill = 0; m_lo = 1'b0;
        rst = 1'b1; pix_data = 16'h0000; pix_valid = 1'b0;
        frame_start = 1'b0; flush = 1'b0; tx_ready = 1'b1;
        #2;
        step(); step();
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_fill", fill_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", pix_count, 0);
        rst = 1'b0;
        got.delete();

        // Basic flow: sync word then one pixel
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step(); step(); step();
        pix_data = 16'h1234; pix_valid = 1'b1; step(); pix_valid = 1'b0;
        repeat (6) step();
        chk("t1_len", got.size(), 4);
        if (got.size() == 4) begin
            chk("t1_b0", got[0], 8'hA5);
            chk("t1_b1", got[1], 8'h5A);
            chk("t1_b2", got[2], 8'h12);
            chk("t1_b3", got[3], 8'h34);
        end
        chk("t1_cnt", pix_count, 1);
        chk("t1_ovf", overflow, 0);

        // Collision: second pixel lands while writer is in LO
        do_reset();
        pix_data = 16'h0102; pix_valid = 1'b1; step();
        pix_data = 16'hBEEF; step(); pix_valid = 1'b0;
        repeat (6) step();
        chk("t2_len", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_b0", got[0], 8'h01);
            chk("t2_b1", got[1], 8'h02);
        end
        chk("t2_ovf", overflow, 1);
        chk("t2_cnt", pix_count, 1);

        // frame_start and pix_valid together
        do_reset();
        frame_start = 1'b1; pix_valid = 1'b1; pix_data = 16'h7777; step();
        frame_start = 1'b0; pix_valid = 1'b0;
        repeat (6) step();
        chk("t3_len", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3_b0", got[0], 8'hA5);
            chk("t3_b1", got[1], 8'h5A);
        end
        chk("t3_ovf", overflow, 1);
        chk("t3_cnt", pix_count, 0);

        // Full FIFO: 8 words fill 16 bytes, 9th dropped
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pix_data = 16'(i); pix_valid = 1'b1; step(); pix_valid = 1'b0;
            step(); step();
            if (i == 7) begin
                chk("t4_fill8", fill_level, 16);
                chk("t4_ovf8", overflow, 0);
            end
            chk("t4_head", tx_data, 8'h00);
        end
        chk("t4_fill9", fill_level, 16);
        chk("t4_ovf9", overflow, 1);
        chk("t4_cnt", pix_count, 8);
        tx_ready = 1'b1;
        repeat (16) step();
        chk("t4_len", got.size(), 16);
        if (got.size() == 16) begin
            for (int w = 0; w < 8; w++) begin
                chk("t4_hi", got[2*w], 8'h00);
                chk("t4_lo", got[2*w+1], 8'(w));
            end
        end
        chk("t4_valid_end", tx_valid, 0);
        chk("t4_fill_end", fill_level, 0);

        // Wrap with tx_ready toggling every cycle
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pix_data = 16'h0100 + 16'(i); pix_valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tx_ready = ~tx_ready;
                step();
                pix_valid = 1'b0;
                chk("t5_fill", fill_level, m_fill);
            end
        end
        for (int c = 0; c < 20; c++) begin
            tx_ready = ~tx_ready;
            step();
            chk("t5_fill", fill_level, m_fill);
        end
        chk("t5_len", got.size(), 80);
        if (got.size() == 80) begin
            for (int i = 0; i < 40; i++) begin
                chk("t5_hi", got[2*i], 8'h01);
                chk("t5_lo", got[2*i+1], 8'(i));
            end
        end
        chk("t5_ovf", overflow, 0);
        chk("t5_valid_end", tx_valid, 0);

        // Flush while in LO with 6 bytes stored and overflow set
        do_reset();
        tx_ready = 1'b0;
        pix_data = 16'h0011; pix_valid = 1'b1; step(); pix_valid = 1'b0; step();
        pix_data = 16'h0022; pix_valid = 1'b1; step();
        pix_data = 16'h0033; step(); pix_valid = 1'b0; step();
        pix_data = 16'h0044; pix_valid = 1'b1; step(); pix_valid = 1'b0; step();
        pix_data = 16'h0055; pix_valid = 1'b1; tx_ready = 1'b1; step();
        pix_valid = 1'b0; tx_ready = 1'b0;
        chk("t6_fill_pre", fill_level, 6);
        chk("t6_ovf_pre", overflow, 1);
        chk("t6_cnt_pre", pix_count, 4);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t6_fill", fill_level, 0);
        chk("t6_valid", tx_valid, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_cnt", pix_count, 0);
        chk("t6_data", tx_data, 8'h00);
        got.delete();
        tx_ready = 1'b1;
        repeat (4) step();
        chk("t6_len", got.size(), 0);
        chk("t6_valid_end", tx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
